// File: rtl/pulse_train_gen_pkg.sv
// Shared definitions for the pulse-train generator: FSM state encoding and
// default counter widths.
package pulse_train_gen_pkg;

    localparam int DEF_CNT_W = 8;
    localparam int DEF_NUM_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_train_gen_load_down_counter.sv
// Loadable down counter that saturates at zero. Load takes priority over
// decrement. 'zero' flags a count of zero.
module load_down_counter
    import pulse_train_gen_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         zero
);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values, independent of the order the always blocks run in.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: N high/low pulses of latched lengths,
// with registered level output, busy/done status and a falling-edge strobe.
module pulse_train_gen
    import pulse_train_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int NUM_W = DEF_NUM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [NUM_W-1:0] num_pulses,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic             fall_strb
);

    state_t state, next_state;

    logic [CNT_W-1:0] high_m1_q, low_m1_q;
    logic [CNT_W-1:0] phase_count, phase_val;
    logic [NUM_W-1:0] pulse_count;
    logic             phase_zero, pulse_zero, phase_load, phase_en;
    logic             accept, reject, high_end, low_end, last_pulse;
    logic             pulse_d, busy_d, done_d, fall_d;

    assign accept     = (state == ST_IDLE) && start && (num_pulses != '0) && (high_len != '0);
    assign reject     = (state == ST_IDLE) && start && !((num_pulses != '0) && (high_len != '0));
    assign high_end   = (state == ST_HIGH) && phase_zero;
    assign low_end    = (state == ST_LOW) && phase_zero;
    assign last_pulse = (pulse_count == NUM_W'(1));

    // Config is captured only on an accepted start; lengths are stored minus one
    // because the phase counter runs from length-1 down to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            high_m1_q <= '0;
            low_m1_q  <= '0;
        end else if (accept) begin
            high_m1_q <= high_len - CNT_W'(1);
            low_m1_q  <= (low_len == '0) ? '0 : low_len - CNT_W'(1);
        end
    end

    assign phase_load = accept || (high_end && !last_pulse) || low_end;
    assign phase_en   = (state != ST_IDLE);
    assign phase_val  = accept             ? high_len - CNT_W'(1) :
                        (state == ST_HIGH) ? low_m1_q : high_m1_q;

    load_down_counter #(.W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (phase_load),
        .load_val (phase_val),
        .en       (phase_en),
        .count    (phase_count),
        .zero     (phase_zero)
    );

    load_down_counter #(.W(NUM_W)) u_pulse_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (num_pulses),
        .en       (high_end && !pulse_zero),
        .count    (pulse_count),
        .zero     (pulse_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept)   next_state = ST_HIGH;
            ST_HIGH: if (high_end) next_state = last_pulse ? ST_IDLE : ST_LOW;
            ST_LOW:  if (low_end)  next_state = ST_HIGH;
            default:               next_state = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state and registered, so they change
    // on the same edge as the state they describe.
    always_comb begin
        pulse_d = (next_state == ST_HIGH);
        busy_d  = (next_state != ST_IDLE);
        fall_d  = high_end;
        done_d  = reject || (high_end && last_pulse);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fall_strb <= 1'b0;
        end else begin
            pulse_out <= pulse_d;
            busy      <= busy_d;
            done      <= done_d;
            fall_strb <= fall_d;
        end
    end

endmodule
